// File: rtl/tea_boot_ctrl.sv
// rtl/tea_boot_ctrl.sv - program loader and run sequencer for one tea_cpu core
// Owns the instruction memory, fills it from a word stream, then runs the core until halt or budget.
module tea_boot_ctrl #(
  parameter int         PC_WIDTH  = 8,
  parameter logic [4:0] HALT_ADDR = 5'h1F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                reload,
  input  logic                abort,
  input  logic [15:0]         run_limit,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [8:0]          ld_data,
  input  logic                ld_last,
  output logic                cpu_rst,
  input  logic [PC_WIDTH-1:0] instr_addr,
  output logic [8:0]          instr,
  input  logic [4:0]          io_addr,
  input  logic                io_wr,
  input  logic [7:0]          io_wrdata,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [7:0]          result,
  output logic [15:0]         cycles,
  output logic [PC_WIDTH:0]   prog_len
);

  localparam int DEPTH = 1 << PC_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BOOT,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t              state, state_nx;
  logic [PC_WIDTH-1:0] wptr;
  logic                boot_cnt;
  logic [8:0]          mem [DEPTH];

  logic        idle_like;
  logic        start_ok;
  logic        beat;
  logic        last_beat;
  logic        halt;
  logic        budget;
  logic        enter_end;
  logic [15:0] cycles_inc;

  assign ld_ready  = (state == S_LOAD);
  assign cpu_rst   = (state != S_RUN);
  assign busy      = (state == S_LOAD) || (state == S_BOOT) || (state == S_RUN);
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_TIMEOUT);
  assign start_ok  = start && idle_like;

  assign beat      = ld_valid && ld_ready;
  assign last_beat = beat && (ld_last || (&wptr));

  assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
  assign halt       = (state == S_RUN) && io_wr && (io_addr == HALT_ADDR);
  assign budget     = (state == S_RUN) && (run_limit != 16'd0) && (cycles_inc == run_limit);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) state_nx = (reload || prog_len == '0) ? S_LOAD : S_BOOT;
      end
      S_LOAD: if (last_beat) state_nx = S_BOOT;
      S_BOOT: if (boot_cnt) state_nx = S_RUN;
      S_RUN: begin
        // halt outranks budget when both land in the same cycle
        if (halt)        state_nx = S_DONE;
        else if (budget) state_nx = S_TIMEOUT;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort && busy) state_nx = S_IDLE;
  end

  assign enter_end = (state == S_RUN) && ((state_nx == S_DONE) || (state_nx == S_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      boot_cnt <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      result   <= 8'h00;
      cycles   <= 16'h0000;
      prog_len <= '0;
    end else begin
      state    <= state_nx;
      done     <= enter_end;
      boot_cnt <= (state == S_BOOT);
      if (state != S_LOAD) wptr <= '0;
      else if (beat)       wptr <= wptr + 1'b1;
      if (beat) prog_len <= {1'b0, wptr} + 1'b1;
      if (start_ok) begin
        timeout <= 1'b0;
        cycles  <= 16'h0000;
      end
      if (state == S_RUN) cycles <= cycles_inc;
      if (enter_end && state_nx == S_DONE)    result  <= io_wrdata;
      if (enter_end && state_nx == S_TIMEOUT) timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) mem[wptr] <= ld_data;
  end

  // words past the loaded program read as zero so stale contents never execute
  assign instr = ({1'b0, instr_addr} < prog_len) ? mem[instr_addr] : 9'h000;

endmodule

// File: tb/tb_tea_boot_ctrl.sv
// tb/tb_tea_boot_ctrl.sv - self-checking bench for tea_boot_ctrl
// A small CPU stand-in issues halt writes; a behavioural model predicts every output each cycle.
module tb_tea_boot_ctrl;

  localparam int DEPTH = 256;
  localparam int M_IDLE = 0, M_LOAD = 1, M_BOOT = 2, M_RUN = 3, M_DONE = 4, M_TIMEOUT = 5;

  logic        clk = 1'b0;
  logic        rst, start, reload, abort;
  logic [15:0] run_limit;
  logic        ld_valid, ld_ready, ld_last;
  logic [8:0]  ld_data;
  logic        cpu_rst;
  logic [7:0]  instr_addr;
  logic [8:0]  instr;
  logic [4:0]  io_addr;
  logic        io_wr;
  logic [7:0]  io_wrdata;
  logic        busy, done, timeout;
  logic [7:0]  result;
  logic [15:0] cycles;
  logic [8:0]  prog_len;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  tea_boot_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .reload(reload), .abort(abort),
    .run_limit(run_limit), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .cpu_rst(cpu_rst),
    .instr_addr(instr_addr), .instr(instr), .io_addr(io_addr), .io_wr(io_wr),
    .io_wrdata(io_wrdata), .busy(busy), .done(done), .timeout(timeout),
    .result(result), .cycles(cycles), .prog_len(prog_len)
  );

  // CPU stand-in: decoy write to 0x1E in run cycle 2, halt write in run cycle halt_at, echoed once
  int         halt_at = 0;
  logic [7:0] halt_data = 8'h00;
  int         cpu_cnt = 0;
  logic       wr_echo = 1'b0;
  logic       wr_pri, decoy;
  logic [7:0] probe_addr = 8'h00;
  bit         probe_auto = 1;

  always @(posedge clk) begin
    cpu_cnt <= cpu_rst ? 0 : cpu_cnt + 1;
    wr_echo <= wr_pri;
  end
  assign wr_pri     = !cpu_rst && halt_at != 0 && cpu_cnt == halt_at - 1;
  assign decoy      = !cpu_rst && cpu_cnt == 1 && halt_at > 2;
  assign io_wr      = wr_pri || wr_echo || decoy;
  assign io_addr    = decoy ? 5'h1E : 5'h1F;
  assign io_wrdata  = decoy ? 8'h77 : halt_data;
  assign instr_addr = cpu_rst ? probe_addr : 8'(cpu_cnt);

  // behavioural model
  int         m_mode = M_IDLE, m_wptr = 0, m_boot = 0, m_prog_len = 0, m_cycles = 0;
  logic [7:0] m_result = 8'h00;
  bit         m_timeout = 0, m_done = 0, m_was_busy = 0;
  logic [8:0] m_mem [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_prog_len = 0; m_result = 8'h00; m_cycles = 0;
      m_timeout = 0; m_done = 0;
    end else begin
      m_was_busy = (m_mode == M_LOAD || m_mode == M_BOOT || m_mode == M_RUN);
      m_done = 0;
      case (m_mode)
        M_IDLE, M_DONE, M_TIMEOUT: if (start) begin
          m_timeout = 0; m_cycles = 0; m_wptr = 0; m_boot = 0;
          m_mode = (reload || m_prog_len == 0) ? M_LOAD : M_BOOT;
        end
        M_LOAD: if (ld_valid) begin
          m_mem[m_wptr] = ld_data;
          m_wptr++;
          m_prog_len = m_wptr;
          if (ld_last || m_wptr == DEPTH) m_mode = M_BOOT;
        end
        M_BOOT: begin
          m_boot++;
          if (m_boot == 2) m_mode = M_RUN;
        end
        M_RUN: begin
          if (m_cycles < 65535) m_cycles++;
          if (!abort && io_wr && io_addr == 5'h1F) begin
            m_result = io_wrdata; m_mode = M_DONE; m_done = 1;
          end else if (!abort && run_limit != 0 && m_cycles == run_limit) begin
            m_mode = M_TIMEOUT; m_timeout = 1; m_done = 1;
          end
        end
        default: m_mode = M_IDLE;
      endcase
      if (abort && m_was_busy) m_mode = M_IDLE;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_rst", cpu_rst, m_mode != M_RUN);
      chk("ld_ready", ld_ready, m_mode == M_LOAD);
      chk("busy", busy, m_mode == M_LOAD || m_mode == M_BOOT || m_mode == M_RUN);
      chk("done", done, m_done);
      chk("timeout", timeout, m_timeout);
      chk("result", result, m_result);
      chk("cycles", cycles, m_cycles);
      chk("prog_len", prog_len, m_prog_len);
      chk("instr", instr, (int'(instr_addr) < m_prog_len) ? m_mem[instr_addr] : 9'h000);
    end
  end

  logic [8:0] prog_q [$];

  task automatic tick;
    @(posedge clk);
    #1;
    if (probe_auto) probe_addr = probe_addr + 8'd37;
  endtask

  task automatic do_start(input bit r);
    start = 1; reload = r;
    tick;
    start = 0; reload = 0;
  endtask

  task automatic load_prog;
    for (int i = 0; i < prog_q.size(); i++) begin
      ld_valid = 1; ld_data = prog_q[i]; ld_last = (i == prog_q.size() - 1);
      tick;
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick;
      n++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic set_prog1;
    prog_q = {9'h15A, 9'h0E4, 9'h09F};
  endtask

  int accepted;
  int n;

  initial begin
    rst = 1; start = 0; reload = 0; abort = 0; run_limit = 16'd0;
    ld_valid = 0; ld_last = 0; ld_data = 9'h000;
    tick;
    chk_en = 1;
    tick; tick;
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_prog_len", prog_len, 9'd0);
    rst = 0;
    tick;

    // load and halt
    halt_at = 5; halt_data = 8'h5A; run_limit = 16'd0; set_prog1;
    do_start(1);
    load_prog;
    wait_done(100);
    chk("s1_prog_len", prog_len, 9'd3);
    chk("s1_result", result, 8'h5A);
    chk("s1_cycles", cycles, 16'd5);
    chk("s1_timeout", timeout, 1'b0);
    chk("s1_cpu_rst", cpu_rst, 1'b1);
    tick;
    chk("s1_done_pulse", done, 1'b0);

    // budget timeout
    halt_at = 0; run_limit = 16'd100; prog_q = {9'h100, 9'h0E2};
    do_start(1);
    load_prog;
    wait_done(300);
    chk("s2_timeout", timeout, 1'b1);
    chk("s2_cycles", cycles, 16'd100);
    chk("s2_result", result, 8'h5A);
    tick;

    // simultaneous halt and budget
    halt_at = 5; halt_data = 8'h5A; run_limit = 16'd5; set_prog1;
    do_start(1);
    load_prog;
    wait_done(100);
    chk("s3_timeout", timeout, 1'b0);
    chk("s3_result", result, 8'h5A);
    chk("s3_cycles", cycles, 16'd5);
    tick;

    // full load without ld_last, valid every other cycle
    halt_at = 3; halt_data = 8'hC3; run_limit = 16'd0; accepted = 0;
    do_start(1);
    for (int i = 0; i <= DEPTH; i++) begin
      ld_valid = 1; ld_last = 0; ld_data = 9'(i) ^ 9'h0A5;
      if (i == DEPTH) chk("s4_ld_ready_257", ld_ready, 1'b0);
      else if (ld_ready === 1'b1) accepted++;
      if (i == DEPTH - 1) begin
        tick;
        chk("s4_prog_len", prog_len, 9'd256);
        chk("s4_boot", busy & cpu_rst & ~ld_ready, 1'b1);
      end else tick;
      ld_valid = 0;
      tick;
    end
    chk("s4_accepted", accepted, 256);
    wait_done(100);
    chk("s4_result", result, 8'hC3);
    chk("s4_cycles", cycles, 16'd3);
    probe_auto = 0;
    probe_addr = 8'd0;   #1; chk("s4_instr0", instr, 9'h0A5);
    probe_addr = 8'd255; #1; chk("s4_instr255", instr, 9'h05A);
    probe_auto = 1;
    tick;

    // abort in the third run cycle, then rerun without reload
    halt_at = 5; halt_data = 8'h5A; set_prog1;
    do_start(1);
    load_prog;
    n = 0;
    while (cpu_rst !== 1'b0 && n < 10) begin
      tick;
      n++;
    end
    chk("s5_run_seen", cpu_rst, 1'b0);
    tick; tick;
    abort = 1;
    tick;
    abort = 0;
    chk("s5_idle", busy, 1'b0);
    chk("s5_cpu_rst", cpu_rst, 1'b1);
    chk("s5_no_done", done, 1'b0);
    chk("s5_result_kept", result, 8'hC3);
    tick; tick; tick;
    do_start(0);
    chk("s5_boot_direct", {busy, ld_ready}, 2'b10);
    wait_done(100);
    chk("s5_result", result, 8'h5A);
    chk("s5_cycles", cycles, 16'd5);
    tick;

    // reset mid-load
    do_start(1);
    ld_valid = 1; ld_data = 9'h1FF; tick;
    ld_data = 9'h0AA; tick;
    ld_valid = 0; rst = 1;
    tick;
    rst = 0;
    chk("s6_prog_len", prog_len, 9'd0);
    chk("s6_ld_ready", ld_ready, 1'b0);
    chk("s6_busy", busy, 1'b0);
    tick;
    do_start(0);
    chk("s6_load", ld_ready, 1'b1);
    load_prog;
    wait_done(100);
    chk("s6_result", result, 8'h5A);
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
